// File: rtl/pdn_rail_sequencer.sv
// Power-up/power-down sequencer for the top-level supply rails: ordered enable with
// pgood timeout and settle time, reverse-order disable, latched fault on timeout/brownout.
module pdn_rail_sequencer #(
   parameter int unsigned NUM_RAILS      = 6,
   parameter int unsigned CNT_W          = 16,
   parameter int unsigned TIMEOUT_CYCLES = 1000,
   parameter int unsigned SETTLE_CYCLES  = 4,
   parameter int unsigned DOWN_CYCLES    = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 pwr_on_req,
   input  logic                 pwr_off_req,
   input  logic                 clear_fault,
   input  logic [NUM_RAILS-1:0] rail_pgood,
   output logic [NUM_RAILS-1:0] rail_en,
   output logic                 seq_busy,
   output logic                 all_good,
   output logic                 fault,
   output logic [2:0]           fault_rail
);

   localparam int unsigned IDX_W = (NUM_RAILS > 1) ? $clog2(NUM_RAILS) : 1;
   localparam logic [CNT_W-1:0]     TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]     SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0]     DOWN_LAST   = CNT_W'(DOWN_CYCLES - 1);
   localparam logic [IDX_W-1:0]     IDX_LAST    = IDX_W'(NUM_RAILS - 1);
   localparam logic [NUM_RAILS-1:0] EN_ONE      = NUM_RAILS'(1);

   typedef enum logic [2:0] {S_OFF, S_UP, S_SETTLE, S_ON, S_DOWN, S_FAULT} state_t;

   state_t               state, state_nxt;
   logic [NUM_RAILS-1:0] pg_meta, pg_s, rail_en_nxt;
   logic [IDX_W-1:0]     idx, idx_nxt;
   logic [CNT_W-1:0]     timer, timer_nxt;
   logic [2:0]           fault_rail_nxt, low_bad;
   logic                 seq_busy_nxt, all_good_nxt, fault_nxt;
   logic                 pg_idx, any_bad, up_timeout, settle_done, down_done;

   assign pg_idx      = pg_s[idx];
   assign any_bad     = ~&pg_s;
   assign up_timeout  = (timer == TO_LAST);
   assign settle_done = (timer == SETTLE_LAST);
   assign down_done   = (timer == DOWN_LAST);

   // Lowest-indexed rail whose synced pgood is low.
   always_comb begin
      low_bad = '0;
      for (int k = NUM_RAILS - 1; k >= 0; k--) begin
         if (!pg_s[k]) low_bad = 3'(k);
      end
   end

   // State, datapath and output registers; pgood passes through a 2-flop synchronizer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= S_OFF;
         pg_meta    <= '0;
         pg_s       <= '0;
         idx        <= '0;
         timer      <= '0;
         rail_en    <= '0;
         seq_busy   <= 1'b0;
         all_good   <= 1'b0;
         fault      <= 1'b0;
         fault_rail <= '0;
      end else begin
         state      <= state_nxt;
         pg_meta    <= rail_pgood;
         pg_s       <= pg_meta;
         idx        <= idx_nxt;
         timer      <= timer_nxt;
         rail_en    <= rail_en_nxt;
         seq_busy   <= seq_busy_nxt;
         all_good   <= all_good_nxt;
         fault      <= fault_nxt;
         fault_rail <= fault_rail_nxt;
      end
   end

   // Next state: fault beats power-off request beats normal progress.
   always_comb begin
      state_nxt = state;
      case (state)
         S_OFF:    if (pwr_on_req && !pwr_off_req) state_nxt = S_UP;
         S_UP: begin
            if (!pg_idx && up_timeout) state_nxt = S_FAULT;
            else if (pwr_off_req)      state_nxt = S_DOWN;
            else if (pg_idx)           state_nxt = S_SETTLE;
         end
         S_SETTLE: begin
            if (!pg_idx)          state_nxt = S_FAULT;
            else if (pwr_off_req) state_nxt = S_DOWN;
            else if (settle_done) state_nxt = (idx == IDX_LAST) ? S_ON : S_UP;
         end
         S_ON: begin
            if (any_bad)          state_nxt = S_FAULT;
            else if (pwr_off_req) state_nxt = S_DOWN;
         end
         S_DOWN:   if (down_done && idx == '0) state_nxt = S_OFF;
         S_FAULT:  if (clear_fault && !pwr_on_req) state_nxt = S_OFF;
         default:  state_nxt = S_OFF;
      endcase
   end

   // Datapath and registered-output next values, keyed on the transition taken.
   always_comb begin
      idx_nxt        = idx;
      timer_nxt      = timer;
      rail_en_nxt    = rail_en;
      fault_rail_nxt = fault_rail;
      seq_busy_nxt   = (state_nxt == S_UP) || (state_nxt == S_SETTLE) || (state_nxt == S_DOWN);
      all_good_nxt   = (state_nxt == S_ON);
      fault_nxt      = (state_nxt == S_FAULT);
      case (state)
         S_OFF: begin
            if (state_nxt == S_UP) begin
               idx_nxt     = '0;
               timer_nxt   = '0;
               rail_en_nxt = EN_ONE;
            end
         end
         S_UP, S_SETTLE, S_ON: begin
            if (state_nxt == S_FAULT) begin
               rail_en_nxt    = '0;
               timer_nxt      = '0;
               fault_rail_nxt = (state == S_ON) ? low_bad : 3'(idx);
            end else if (state_nxt == S_DOWN) begin
               idx_nxt     = (state == S_ON) ? IDX_LAST : idx;
               rail_en_nxt = rail_en & ~(EN_ONE << idx_nxt);
               timer_nxt   = '0;
            end else if (state == S_UP && state_nxt == S_SETTLE) begin
               timer_nxt = '0;
            end else if (state == S_SETTLE && state_nxt == S_UP) begin
               idx_nxt     = idx + IDX_W'(1);
               rail_en_nxt = rail_en | (EN_ONE << (idx + IDX_W'(1)));
               timer_nxt   = '0;
            end else if (state_nxt == S_ON) begin
               timer_nxt = '0;
            end else begin
               timer_nxt = timer + CNT_W'(1);
            end
         end
         S_DOWN: begin
            if (!down_done) begin
               timer_nxt = timer + CNT_W'(1);
            end else if (idx != '0) begin
               idx_nxt     = idx - IDX_W'(1);
               rail_en_nxt = rail_en & ~(EN_ONE << (idx - IDX_W'(1)));
               timer_nxt   = '0;
            end else begin
               idx_nxt   = '0;
               timer_nxt = '0;
            end
         end
         S_FAULT: begin
            if (state_nxt == S_OFF) begin
               idx_nxt   = '0;
               timer_nxt = '0;
            end
         end
         default: ;
      endcase
   end

endmodule
